// File: rtl/lifo_arb_pkg.sv
// Shared types and helpers for the LIFO arbiter slice.
//   op_t      : operation a requester is asking for this cycle
//   req_idx_w : width of a requester index (at least 1 bit)
package lifo_arb_pkg;

  localparam int unsigned N_REQ_DEFAULT  = 4;
  localparam int unsigned DWIDTH_DEFAULT = 16;

  typedef enum logic [1:0] {
    OP_NONE,
    OP_PUSH,
    OP_POP
  } op_t;

  function automatic int unsigned req_idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Generic round-robin arbiter.
//   clk_i     : clock
//   arst_i    : asynchronous active-high reset (pointer -> N-1, index 0 first)
//   elig_i    : per-requester eligibility
//   gnt_o     : one-hot grant (or zero), combinational
//   gnt_idx_o : index of the granted requester
//   gnt_vld_o : a grant is present this cycle
module rr_arbiter
  import lifo_arb_pkg::*;
#(
  parameter int unsigned N    = N_REQ_DEFAULT,
  parameter int unsigned IdxW = req_idx_w(N)
) (
  input  logic            clk_i,
  input  logic            arst_i,
  input  logic [N-1:0]    elig_i,
  output logic [N-1:0]    gnt_o,
  output logic [IdxW-1:0] gnt_idx_o,
  output logic            gnt_vld_o
);

  logic [IdxW-1:0] r_ptr;
  logic [IdxW-1:0] w_idx;
  logic            w_found;
  logic [N-1:0]    w_gnt;

  // Search starts strictly after the last winner and wraps, so the last
  // winner is considered last.
  always_comb begin
    int unsigned idx;
    w_found = 1'b0;
    w_idx   = '0;
    w_gnt   = '0;
    for (int unsigned off = 1; off <= N; off++) begin
      idx = 32'(r_ptr) + off;
      if (idx >= N) idx = idx - N;
      if (!w_found && elig_i[idx]) begin
        w_found = 1'b1;
        w_idx   = IdxW'(idx);
      end
    end
    for (int unsigned k = 0; k < N; k++) begin
      w_gnt[k] = w_found && (w_idx == IdxW'(k));
    end
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      r_ptr <= IdxW'(N - 1);
    end else if (w_found) begin
      r_ptr <= w_idx;
    end
  end

  assign gnt_o     = w_gnt;
  assign gnt_idx_o = w_idx;
  assign gnt_vld_o = w_found;

endmodule

// File: rtl/lifo_arbiter.sv
// Shares one LIFO between N_REQ requesters with round-robin arbitration.
// At most one push or pop reaches the LIFO per cycle; pop data is routed back
// to the granted requester one cycle later.
//   clk_i, arst_i           : clock, asynchronous active-high reset
//   req_push_i/req_pop_i    : per-requester level requests, held until ready
//   req_data_i              : push data, slice k for requester k
//   req_ready_o             : one-hot grant
//   rsp_valid_o/rsp_data_o  : one-hot pop response and shared pop data
//   lifo_*                  : connection to the LIFO ports
module lifo_arbiter
  import lifo_arb_pkg::*;
#(
  parameter int unsigned N_REQ  = N_REQ_DEFAULT,
  parameter int unsigned DWIDTH = DWIDTH_DEFAULT
) (
  input  logic                    clk_i,
  input  logic                    arst_i,
  input  logic [N_REQ-1:0]        req_push_i,
  input  logic [N_REQ-1:0]        req_pop_i,
  input  logic [N_REQ*DWIDTH-1:0] req_data_i,
  output logic [N_REQ-1:0]        req_ready_o,
  output logic [N_REQ-1:0]        rsp_valid_o,
  output logic [DWIDTH-1:0]       rsp_data_o,
  output logic                    lifo_wrreq_o,
  output logic [DWIDTH-1:0]       lifo_data_o,
  output logic                    lifo_rdreq_o,
  input  logic [DWIDTH-1:0]       lifo_q_i,
  input  logic                    lifo_empty_i,
  input  logic                    lifo_full_i
);

  localparam int unsigned REQ_IDX_W = req_idx_w(N_REQ);

  op_t                  w_op [N_REQ];
  logic [N_REQ-1:0]     w_elig;
  logic [N_REQ-1:0]     w_gnt;
  logic [REQ_IDX_W-1:0] w_gnt_idx;
  logic                 w_gnt_vld;
  op_t                  w_gnt_op;
  logic [N_REQ-1:0]     r_rsp_valid;

  // Push has priority over a simultaneous pop from the same requester; the
  // pop stays pending. A requester whose selected op is blocked simply waits.
  // Eligibility is masked during reset so nothing reaches the LIFO.
  always_comb begin
    for (int unsigned k = 0; k < N_REQ; k++) begin
      w_op[k] = OP_NONE;
      if (req_push_i[k])     w_op[k] = OP_PUSH;
      else if (req_pop_i[k]) w_op[k] = OP_POP;
      w_elig[k] = !arst_i && (((w_op[k] == OP_PUSH) && !lifo_full_i) ||
                              ((w_op[k] == OP_POP)  && !lifo_empty_i));
    end
  end

  rr_arbiter #(
    .N    (N_REQ),
    .IdxW (REQ_IDX_W)
  ) u_rr_arbiter (
    .clk_i     (clk_i),
    .arst_i    (arst_i),
    .elig_i    (w_elig),
    .gnt_o     (w_gnt),
    .gnt_idx_o (w_gnt_idx),
    .gnt_vld_o (w_gnt_vld)
  );

  always_comb begin
    w_gnt_op     = OP_NONE;
    lifo_data_o  = '0;
    if (w_gnt_vld) w_gnt_op = w_op[w_gnt_idx];
    lifo_wrreq_o = (w_gnt_op == OP_PUSH);
    lifo_rdreq_o = (w_gnt_op == OP_POP);
    if (lifo_wrreq_o) lifo_data_o = req_data_i[w_gnt_idx*DWIDTH +: DWIDTH];
  end

  // LIFO read latency is one cycle, so the response flag is the pop grant
  // delayed by one register stage.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      r_rsp_valid <= '0;
    end else begin
      r_rsp_valid <= w_gnt & {N_REQ{lifo_rdreq_o}};
    end
  end

  assign req_ready_o = w_gnt;
  assign rsp_valid_o = r_rsp_valid;
  assign rsp_data_o  = (|r_rsp_valid) ? lifo_q_i : '0;

endmodule

// File: doc/lifo_arbiter.md
Name: lifo_arbiter

Overview:
- Shares one `lifo` instance (DWIDTH data, 1-cycle read latency, registered flags) between N_REQ requesters.
- Each requester issues push or pop through a valid/ready handshake.
- Round-robin grant, at most one LIFO operation per cycle; pop data is routed back to the requester that was granted.
- Sits between client blocks and the `lifo` ports: wrreq_i, data_i, rdreq_i, q_o, empty_o, full_o.

Parameters:
- N_REQ, 4, number of requesters (2..16)
- DWIDTH, 16, data width; must equal the `lifo` DWIDTH

Ports:
- clk_i  in  1  clock
- arst_i  in  1  reset, asynchronous, active-high
- req_push_i  in  N_REQ  per-requester push request (level, held until ready)
- req_pop_i  in  N_REQ  per-requester pop request (level, held until ready)
- req_data_i  in  N_REQ*DWIDTH  push data; slice k belongs to requester k
- req_ready_o  out  N_REQ  one-hot grant; transfer when request & ready
- rsp_valid_o  out  N_REQ  one-hot, pop data valid for requester k
- rsp_data_o  out  DWIDTH  pop data, shared by all requesters
- lifo_wrreq_o  out  1  to `lifo` wrreq_i
- lifo_data_o  out  DWIDTH  to `lifo` data_i
- lifo_rdreq_o  out  1  to `lifo` rdreq_i
- lifo_q_i  in  DWIDTH  from `lifo` q_o
- lifo_empty_i  in  1  from `lifo` empty_o
- lifo_full_i  in  1  from `lifo` full_o

Behaviour:
- Reset (arst_i=1, asynchronous):
  - RR pointer = N_REQ-1, so requester 0 has highest priority first.
  - rsp_valid_o = 0.
  - Combinational outputs follow: req_ready_o=0, lifo_wrreq_o=0, lifo_rdreq_o=0 while reset is asserted.
- Per-requester op select: push wins if req_push_i[k] and req_pop_i[k] are both 1. The pop stays pending and is served in a later grant.
- Eligibility:
  - push: eligible when !lifo_full_i.
  - pop: eligible when !lifo_empty_i.
  - Ineligible requests wait; they are never dropped and never produce error pulses.
- Flag timing: flags at cycle t reflect every op issued through t-1, so one op per cycle never overflows or underflows.
- Grant: combinational.
  - Picks the first eligible requester strictly after the RR pointer, wrapping modulo N_REQ.
  - req_ready_o is one-hot or zero.
  - The pointer updates to the granted index at the clock edge; it holds if there is no grant.
- LIFO drive: combinational from the grant.
  - Push grant k: lifo_wrreq_o=1, lifo_data_o=req_data_i slice k.
  - Pop grant k: lifo_rdreq_o=1.
  - wrreq and rdreq are never both 1.
  - lifo_data_o = 0 when there is no push grant.
- Response:
  - Pop granted to k in cycle t gives rsp_valid_o[k]=1 in cycle t+1 (registered one-hot).
  - rsp_data_o = lifo_q_i (pass-through) whenever rsp_valid_o != 0; 0 otherwise.
  - Back-to-back pops give back-to-back responses.
- Reset mid-operation: a pop granted in the cycle before arst_i produces no response. The LIFO reset (srst_i) is owned by the integrator, not this block.
- No internal occupancy count; the LIFO flags are authoritative.

Decomposition:
- Package lifo_arb_pkg:
  - REQ_IDX_W = $clog2(N_REQ)
  - typedef op_t enum {OP_NONE, OP_PUSH, OP_POP}
- Sub-module rr_arbiter:
  - Generic N-bit eligible vector in, one-hot grant plus index out.
  - Pointer register updated on grant.
  - Reused elsewhere.

Test Plan (N_REQ=4, DWIDTH=16, lifo AWIDTH=8):
- Requesters 0..3 push 0x1000+k together from reset -> grants in order 0,1,2,3 on consecutive cycles; requester 2 then pops 4 times -> rsp_valid_o=4'b0100 each following cycle with data 0x1003, 0x1002, 0x1001, 0x1000.
- Requester 0 pushes 256 words until full; requester 1 holds a push -> req_ready_o[1]=0 and lifo_wrreq_o=0; requester 3 pops once -> requester 1 is granted the very next cycle, usedw stays 256, no overflow.
- Requester 1 pops on empty for 5 cycles -> no ready, lifo_rdreq_o=0; requester 0 pushes 0xBEEF -> requester 1 granted next cycle, rsp_data_o=0xBEEF one cycle later.
- Requester 2 asserts push (0x00AA) and pop together -> push granted first; pop granted on its next turn returns 0x00AA.
- Requesters 0 and 3 push continuously -> grants alternate 0,3,0,3; no requester waits more than N_REQ-1 cycles.
- arst_i pulsed the cycle after a pop grant -> rsp_valid_o goes 0 immediately, no response; after release requester 0 has first priority.
